nco_baud_gen: RTL and testbench

Programmable phase-accumulator (NCO) baud/sample-tick generator for the UART TX/RX datapaths, running from the 100 MHz system clock. It produces a fractional-rate one-cycle sample-tick strobe and an oversampled bit-tick strobe. It also produces a ~50% duty divided clock. The increment is reprogrammable at run time with glitch-free (tick-aligned) update, and the phase can be re-aligned on demand, e.g. on an RX start-bit edge.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/nco_baud_gen.sv | 108 ++++++++++
 tb/tb_nco_baud_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART timing constants and the increment calculator used to
// program the NCO baud/sample-tick generator.
package uart_pkg;

    localparam longint unsigned CLK_HZ       = 100_000_000;
    localparam int unsigned     DEFAULT_BAUD = 9600;
    localparam int unsigned     DEFAULT_OVS  = 16;

    // Phase increment giving baud*ovs ticks per second: round(2^acc_w * baud * ovs / CLK_HZ).
    function automatic longint unsigned inc_for(
        input longint unsigned baud,
        input longint unsigned ovs,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (64'd1 << acc_w) * baud * ovs;
        return (num + CLK_HZ / 2) / CLK_HZ;
    endfunction

endpackage

// File: rtl/nco_baud_gen.sv
// Phase-accumulator baud generator: fractional-rate sample tick, every
// OVS-th sample tick as a bit tick, and a divided clock from the phase MSB.
// The increment is double-buffered and only swapped at a period boundary.
module nco_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned       ACC_W     = 32,
    parameter int unsigned       OVS       = DEFAULT_OVS,
    parameter logic [ACC_W-1:0]  INC_RESET = ACC_W'(inc_for(DEFAULT_BAUD, DEFAULT_OVS, ACC_W)),
    localparam int unsigned      OVS_W     = $clog2(OVS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             cfg_we,
    output logic             cfg_pending,
    output logic [ACC_W-1:0] inc_active,
    output logic             sample_tick,
    output logic             bit_tick,
    output logic [OVS_W-1:0] sample_idx,
    output logic             div_clk
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_active_q, inc_active_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             cfg_pending_q, cfg_pending_d;
    logic             sample_tick_q, sample_tick_d;
    logic             div_clk_q, div_clk_d;
    logic [OVS_W-1:0] sample_idx_q, sample_idx_d;

    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic             idx_last;
    logic             apply;

    // Phase addition one bit wider so the carry-out marks the period wrap.
    always_comb begin
        sum_ext  = {1'b0, acc_q} + {1'b0, inc_active_q};
        carry    = sum_ext[ACC_W];
        idx_last = (sample_idx_q == OVS_W'(OVS - 1));
    end

    // Accumulator, tick strobe and divided clock; restart beats enable.
    always_comb begin
        acc_d         = acc_q;
        sample_tick_d = 1'b0;
        div_clk_d     = div_clk_q;
        if (restart) begin
            acc_d     = '0;
            div_clk_d = 1'b0;
        end else if (en) begin
            acc_d         = sum_ext[ACC_W-1:0];
            sample_tick_d = carry;
            div_clk_d     = sum_ext[ACC_W-1];
        end
    end

    // Oversample position within the bit, advancing on each presented tick.
    always_comb begin
        sample_idx_d = sample_idx_q;
        if (restart) begin
            sample_idx_d = '0;
        end else if (sample_tick_q) begin
            sample_idx_d = idx_last ? '0 : sample_idx_q + 1'b1;
        end
    end

    // Shadow increment is swapped in on the wrap edge (so the next period is
    // whole), while frozen, or on restart; a new write always re-arms pending.
    always_comb begin
        apply         = cfg_pending_q & (restart | ~en | carry);
        shadow_d      = cfg_we ? cfg_inc : shadow_q;
        cfg_pending_d = cfg_we | (cfg_pending_q & ~apply);
        inc_active_d  = apply ? shadow_q : inc_active_q;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            inc_active_q  <= INC_RESET;
            shadow_q      <= '0;
            cfg_pending_q <= 1'b0;
            sample_tick_q <= 1'b0;
            sample_idx_q  <= '0;
            div_clk_q     <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            inc_active_q  <= inc_active_d;
            shadow_q      <= shadow_d;
            cfg_pending_q <= cfg_pending_d;
            sample_tick_q <= sample_tick_d;
            sample_idx_q  <= sample_idx_d;
            div_clk_q     <= div_clk_d;
        end
    end

    assign cfg_pending = cfg_pending_q;
    assign inc_active  = inc_active_q;
    assign sample_tick = sample_tick_q;
    assign bit_tick    = sample_tick_q & idx_last;
    assign sample_idx  = sample_idx_q;
    assign div_clk     = div_clk_q;

endmodule

// File: tb/tb_nco_baud_gen.sv
// Bench for nco_baud_gen: a small 8-bit / OVS=4 instance driven through
// reset, restart, reconfiguration, enable gating and async reset, plus a
// default-parameter instance run long enough to measure its tick rate.
module tb_nco_baud_gen;
    import uart_pkg::*;

    typedef struct {
        int cyc;
        int idx;
        bit bt;
    } exp_t;

    logic       clk;
    logic       rst_n, en, restart, cfg_we;
    logic [7:0] cfg_inc;
    logic       cfg_pending, sample_tick, bit_tick, div_clk;
    logic [7:0] inc_active;
    logic [1:0] sample_idx;

    logic        rst2_n, en2, restart2, cfg_we2;
    logic [31:0] cfg_inc2;
    logic        cfg_pending2, sample_tick2, bit_tick2, div_clk2;
    logic [31:0] inc_active2;
    logic [3:0]  sample_idx2;

    int   cyc = 0;
    int   total_cnt = 0;
    int   bad_cnt = 0;
    bit   dut2_done = 0;
    exp_t sb[$];

    nco_baud_gen #(.ACC_W(8), .OVS(4), .INC_RESET(8'd64)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .cfg_inc(cfg_inc), .cfg_we(cfg_we), .cfg_pending(cfg_pending),
        .inc_active(inc_active), .sample_tick(sample_tick), .bit_tick(bit_tick),
        .sample_idx(sample_idx), .div_clk(div_clk)
    );

    nco_baud_gen dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .restart(restart2),
        .cfg_inc(cfg_inc2), .cfg_we(cfg_we2), .cfg_pending(cfg_pending2),
        .inc_active(inc_active2), .sample_tick(sample_tick2), .bit_tick(bit_tick2),
        .sample_idx(sample_idx2), .div_clk(div_clk2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int idx);
        exp_t e;
        e.cyc = c;
        e.idx = idx;
        e.bt  = (idx == 3);
        sb.push_back(e);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every presented tick must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && sample_tick) begin
            total_cnt++;
            if (sb.size() == 0) begin
                bad_cnt++;
                $display("FAIL unexpected_tick: tick at cyc %0d idx %0d bit %0d, none expected",
                         cyc, sample_idx, bit_tick);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || int'(sample_idx) != e.idx || bit_tick != e.bt) begin
                    bad_cnt++;
                    $display("FAIL tick: got cyc %0d idx %0d bit %0d expected cyc %0d idx %0d bit %0d",
                             cyc, sample_idx, bit_tick, e.cyc, e.idx, e.bt);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Default-parameter instance: reset value and long-run tick rate.
    initial begin
        int n_tick;
        int n_bit;
        n_tick   = 0;
        n_bit    = 0;
        rst2_n   = 1'b0;
        en2      = 1'b1;
        restart2 = 1'b0;
        cfg_we2  = 1'b0;
        cfg_inc2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("dflt_rst_inc_active", inc_active2, 64'd6597070);
        chk("dflt_rst_sample_tick", sample_tick2, 0);
        chk("dflt_rst_sample_idx", sample_idx2, 0);
        chk("dflt_rst_div_clk", div_clk2, 0);
        rst2_n = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (sample_tick2) n_tick++;
            if (bit_tick2) n_bit++;
        end
        total_cnt++;
        if (n_tick < 30 || n_tick > 31) begin
            bad_cnt++;
            $display("FAIL dflt_tick_count: got %0d expected 30..31", n_tick);
        end
        chk("dflt_bit_count", n_bit, 1);
        dut2_done = 1'b1;
    end

    // Directed sequence for the 8-bit instance.
    initial begin
        int r, t, u, rises;
        logic prev;
        int jl[9];
        jl = '{3, 6, 8, 11, 14, 16, 19, 22, 24};

        rst_n = 1'b0; en = 1'b1; restart = 1'b0; cfg_we = 1'b0; cfg_inc = '0;
        step_to(3);
        chk("rst_sample_tick", sample_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_sample_idx", sample_idx, 0);
        chk("rst_div_clk", div_clk, 0);
        chk("rst_inc_active", inc_active, 64);
        chk("rst_cfg_pending", cfg_pending, 0);

        // inc=64 from reset release: ticks every 4 edges, bit tick every 16.
        rst_n = 1'b1;
        r = cyc;
        for (int k = 0; k < 6; k++) push(r + 4 + 4 * k, k % 4);
        step_to(r + 27);
        chk("idx_before_restart", sample_idx, 2);

        // Restart at acc=192 with a simultaneous config write.
        restart = 1'b1; cfg_we = 1'b1; cfg_inc = 8'd64;
        step_to(r + 28);
        restart = 1'b0; cfg_we = 1'b0;
        t = cyc;
        chk("restart_idx", sample_idx, 0);
        chk("restart_div_clk", div_clk, 0);
        chk("restart_tick", sample_tick, 0);
        chk("restart_pending", cfg_pending, 1);
        push(t + 4, 0);
        push(t + 8, 1);
        step_to(t + 3);
        chk("pending_before_wrap", cfg_pending, 1);
        step_to(t + 4);
        chk("pending_cleared_on_wrap", cfg_pending, 0);

        // Mid-period write of 128: applied on the next wrap, then period 2.
        step_to(t + 9);
        cfg_we = 1'b1; cfg_inc = 8'd128;
        step_to(t + 10);
        cfg_we = 1'b0;
        chk("cfg_pending_set", cfg_pending, 1);
        chk("cfg_inc_old", inc_active, 64);
        push(t + 12, 2); push(t + 14, 3); push(t + 16, 0);
        push(t + 18, 1); push(t + 20, 2); push(t + 22, 3);
        step_to(t + 12);
        chk("cfg_pending_clear", cfg_pending, 0);
        chk("cfg_inc_new", inc_active, 128);

        // Freeze at acc=128 with a pending write of 64.
        step_to(t + 22);
        cfg_we = 1'b1; cfg_inc = 8'd64;
        step_to(t + 23);
        cfg_we = 1'b0;
        chk("freeze_pending_set", cfg_pending, 1);
        chk("freeze_inc_before", inc_active, 128);
        en = 1'b0;
        step_to(t + 24);
        chk("freeze_pending_applied", cfg_pending, 0);
        chk("freeze_inc_applied", inc_active, 64);
        step_to(t + 33);
        chk("freeze_div_clk_held", div_clk, 1);
        chk("freeze_no_tick", sample_tick, 0);
        en = 1'b1;
        push(t + 35, 0);
        step_to(t + 35);
        cfg_we = 1'b1; cfg_inc = 8'd200;
        step_to(t + 36);
        cfg_we = 1'b0;
        step_to(t + 37);
        chk("prerst_pending", cfg_pending, 1);
        chk("prerst_div_clk", div_clk, 1);
        chk("prerst_idx", sample_idx, 1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tick", sample_tick, 0);
        chk("async_rst_idx", sample_idx, 0);
        chk("async_rst_div_clk", div_clk, 0);
        chk("async_rst_inc", inc_active, 64);
        chk("async_rst_pending", cfg_pending, 0);

        // inc=96 loaded while frozen: 3 ticks per 8 edges.
        @(posedge clk);
        #1;
        en = 1'b0; rst_n = 1'b1;
        u = cyc;
        cfg_we = 1'b1; cfg_inc = 8'd96;
        step_to(u + 1);
        cfg_we = 1'b0;
        chk("inc96_pending", cfg_pending, 1);
        step_to(u + 2);
        chk("inc96_pending_clear", cfg_pending, 0);
        chk("inc96_inc_active", inc_active, 96);
        en = 1'b1;
        for (int k = 0; k < 9; k++) push(u + 2 + jl[k], k % 4);
        rises = 0;
        prev  = div_clk;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (div_clk && !prev) rises++;
            prev = div_clk;
        end
        chk("inc96_div_clk_rises", rises, 9);
        en = 1'b0;
        step_to(u + 32);

        for (int i = 0; i < 30000 && !dut2_done; i++) @(posedge clk);
        total_cnt++;
        if (!dut2_done) begin
            bad_cnt++;
            $display("FAIL dflt_done: default instance did not finish, got 0 expected 1");
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
